instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 22 ++
 rtl/instruction_fetch.sv | 57 +++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory request/response, branch redirect and decode handshake of the fetch stage
interface instruction_fetch_if;
  logic        redirect;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  modport master (
    input  redirect, pc_target, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr, instr_pc, pc_plus4, instr_valid
  );
  modport slave (
    output redirect, pc_target, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr, instr_pc, pc_plus4, instr_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: one-outstanding-request fetch stage holding a single instruction for decode
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_if.master        bus,
  output logic                       misalign_err,
  output logic [31:0]                fetch_count
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0]  state, state_nx;
  logic [31:0] pc, instr_q, instr_pc_q, pc_plus4_q;
  logic        req_q, valid_q, hs, redir, capture;
  assign hs      = valid_q & bus.instr_ready;
  assign redir   = bus.redirect & (state != BOOT);
  assign capture = (state == REQ) & bus.imem_ack & ~redir;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus4    = pc_plus4_q;
  assign bus.instr_valid = valid_q;
  // redirect outranks everything outside BOOT; HOLD leaves only on a handshake
  always_comb
    state_nx = (state == BOOT || redir) ? REQ :
               (state == REQ)           ? (bus.imem_ack ? HOLD : REQ) :
               (state == HOLD && !hs)   ? HOLD : REQ;
  // registered state, PC, held instruction and status; request/valid registered from next state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= {RESET_PC[31:2], 2'b00};
      instr_q      <= '0;
      instr_pc_q   <= '0;
      pc_plus4_q   <= 32'd4;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state   <= state_nx;
      req_q   <= state_nx == REQ;
      valid_q <= state_nx == HOLD;
      if (redir) pc <= {bus.pc_target[31:2], 2'b00};
      else if (capture) pc <= pc + 32'd4;
      if (capture) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= pc;
        pc_plus4_q <= pc + 32'd4;
      end
      if (redir && bus.pc_target[1:0] != 2'b00) misalign_err <= 1'b1;
      if (hs) fetch_count <= fetch_count + 32'd1;
    end
endmodule
